// File: rtl/poker_settle.sv
// Round settlement for two-player Indian poker: picks the winner from the latched
// end-of-round result and moves chips from the loser to the winner, one chip per clock.
module poker_settle #(
    parameter int W          = 8,
    parameter int INIT_CHIPS = 20,
    parameter int FOLD_PEN   = 10
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         settle,
    input  logic [3:0]   card_a,
    input  logic [3:0]   card_b,
    input  logic [W-1:0] bet_a,
    input  logic [W-1:0] bet_b,
    input  logic         fold_a,
    input  logic         fold_b,
    output logic [W-1:0] chips_a,
    output logic [W-1:0] chips_b,
    output logic [1:0]   winner,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         game_over,
    output logic [2:0]   dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EVAL = 3'd1;
    localparam logic [2:0] S_PAY  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    localparam logic [W-1:0] INIT_VAL = W'(INIT_CHIPS);
    localparam logic [W:0]   PEN_VAL  = (W+1)'(FOLD_PEN);

    logic [2:0]   state;
    logic [W:0]   remaining;
    logic         a_pays;
    logic [3:0]   l_card_a;
    logic [3:0]   l_card_b;
    logic [W-1:0] l_bet_a;
    logic [W-1:0] l_bet_b;
    logic         l_fold_a;
    logic         l_fold_b;

    logic         bad_card;
    logic [1:0]   eval_winner;
    logic [W:0]   eval_amount;
    logic [W:0]   loser_bal;
    logic [W:0]   eval_remaining;

    assign bad_card = (l_card_a == 4'd0) || (l_card_a > 4'd10) ||
                      (l_card_b == 4'd0) || (l_card_b > 4'd10);

    // Outcome of the latched round; amount is W+1 bits so bet plus penalty cannot wrap.
    always_comb begin
        eval_winner = 2'b00;
        eval_amount = '0;
        if (bad_card) begin
            eval_winner = 2'b00;
        end else if (l_fold_a && l_fold_b) begin
            eval_winner = 2'b11;
        end else if (l_fold_a) begin
            eval_winner = 2'b10;
            eval_amount = {1'b0, l_bet_a} + ((l_card_a == 4'd10) ? PEN_VAL : '0);
        end else if (l_fold_b) begin
            eval_winner = 2'b01;
            eval_amount = {1'b0, l_bet_b} + ((l_card_b == 4'd10) ? PEN_VAL : '0);
        end else if (l_card_a > l_card_b) begin
            eval_winner = 2'b01;
            eval_amount = {1'b0, l_bet_b};
        end else if (l_card_b > l_card_a) begin
            eval_winner = 2'b10;
            eval_amount = {1'b0, l_bet_a};
        end else begin
            eval_winner = 2'b11;
        end
    end

    assign loser_bal      = (eval_winner == 2'b10) ? {1'b0, chips_a} : {1'b0, chips_b};
    assign eval_remaining = (eval_amount < loser_bal) ? eval_amount : loser_bal;

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state     <= S_IDLE;
            chips_a   <= INIT_VAL;
            chips_b   <= INIT_VAL;
            winner    <= 2'b00;
            remaining <= '0;
            a_pays    <= 1'b0;
            l_card_a  <= '0;
            l_card_b  <= '0;
            l_bet_a   <= '0;
            l_bet_b   <= '0;
            l_fold_a  <= 1'b0;
            l_fold_b  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (settle) begin
                        l_card_a <= card_a;
                        l_card_b <= card_b;
                        l_bet_a  <= bet_a;
                        l_bet_b  <= bet_b;
                        l_fold_a <= fold_a;
                        l_fold_b <= fold_b;
                        state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    winner    <= eval_winner;
                    a_pays    <= (eval_winner == 2'b10);
                    if (bad_card) begin
                        remaining <= '0;
                        state     <= S_DONE;
                    end else begin
                        remaining <= eval_remaining;
                        state     <= (eval_remaining != '0) ? S_PAY : S_DONE;
                    end
                end
                S_PAY: begin
                    if (a_pays) begin
                        chips_a <= chips_a - 1'b1;
                        chips_b <= chips_b + 1'b1;
                    end else begin
                        chips_a <= chips_a + 1'b1;
                        chips_b <= chips_b - 1'b1;
                    end
                    remaining <= remaining - 1'b1;
                    if (remaining == (W+1)'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= ((chips_a == '0) || (chips_b == '0)) ? S_OVER : S_IDLE;
                end
                S_OVER: begin
                    state <= S_OVER;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == S_EVAL) || (state == S_PAY) || (state == S_DONE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_EVAL) && bad_card;
    assign game_over = (state == S_OVER);
    assign dbg_state = state;

endmodule

// File: tb/tb_poker_settle.sv
// Randomized bench for poker_settle against a rule-level model of chip balances.
module tb_poker_settle;
    localparam int W    = 8;
    localparam int INIT = 20;
    localparam int PEN  = 10;

    logic         CLK = 1'b0;
    logic         CLR = 1'b0;
    logic         settle = 1'b0;
    logic [3:0]   card_a = '0;
    logic [3:0]   card_b = '0;
    logic [W-1:0] bet_a = '0;
    logic [W-1:0] bet_b = '0;
    logic         fold_a = 1'b0;
    logic         fold_b = 1'b0;
    logic [W-1:0] chips_a;
    logic [W-1:0] chips_b;
    logic [1:0]   winner;
    logic         busy;
    logic         done;
    logic         err;
    logic         game_over;
    logic [2:0]   dbg_state;

    poker_settle #(.W(W), .INIT_CHIPS(INIT), .FOLD_PEN(PEN)) dut (
        .CLK(CLK), .CLR(CLR), .settle(settle),
        .card_a(card_a), .card_b(card_b), .bet_a(bet_a), .bet_b(bet_b),
        .fold_a(fold_a), .fold_b(fold_b),
        .chips_a(chips_a), .chips_b(chips_b), .winner(winner),
        .busy(busy), .done(done), .err(err), .game_over(game_over),
        .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int bal_a    = INIT;
    int bal_b    = INIT;
    int exp_win  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        CLR = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        CLR   = 1'b1;
        bal_a = INIT;
        bal_b = INIT;
        exp_win = 0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_chips_a"}, chips_a, bal_a);
        check({tag, "_chips_b"}, chips_b, bal_b);
        check({tag, "_winner"}, winner, exp_win);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_game_over"}, game_over, 0);
    endtask

    function automatic int rand_card();
        if ($urandom_range(0, 15) == 0) return $urandom_range(0, 1) ? 0 : $urandom_range(11, 15);
        return $urandom_range(1, 10);
    endfunction

    task automatic run_round(input int ca, input int cb, input int ba, input int bb,
                             input bit fa, input bit fb, input bit noisy);
        bit bad;
        int amt, n, done_cyc;
        bad = (ca == 0) || (ca > 10) || (cb == 0) || (cb > 10);
        amt = 0;
        if (bad)                  exp_win = 0;
        else if (fa && fb)        exp_win = 3;
        else if (fa) begin        exp_win = 2; amt = ba + ((ca == 10) ? PEN : 0); end
        else if (fb) begin        exp_win = 1; amt = bb + ((cb == 10) ? PEN : 0); end
        else if (ca > cb) begin   exp_win = 1; amt = bb; end
        else if (cb > ca) begin   exp_win = 2; amt = ba; end
        else                      exp_win = 3;
        n = 0;
        if (exp_win == 1) n = (amt < bal_b) ? amt : bal_b;
        if (exp_win == 2) n = (amt < bal_a) ? amt : bal_a;

        @(negedge CLK);
        card_a = 4'(ca); card_b = 4'(cb); bet_a = W'(ba); bet_b = W'(bb);
        fold_a = fa; fold_b = fb; settle = 1'b1;
        @(posedge CLK);
        done_cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                settle = 1'b0;
                check("err_in_eval", err, bad);
                check("busy_in_eval", busy, 1);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (noisy) begin
                settle = 1'($urandom_range(0, 1));
                card_a = 4'($urandom); card_b = 4'($urandom);
                bet_a  = W'($urandom); bet_b  = W'($urandom);
                fold_a = 1'($urandom); fold_b = 1'($urandom);
            end
        end
        settle = 1'b0;
        check("done_cycle", done_cyc, n + 2);
        if (exp_win == 1) begin bal_a += n; bal_b -= n; end
        if (exp_win == 2) begin bal_a -= n; bal_b += n; end
        check("winner", winner, exp_win);
        check("chips_a", chips_a, bal_a);
        check("chips_b", chips_b, bal_b);
        @(negedge CLK);
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        check("game_over", game_over, (bal_a == 0) || (bal_b == 0));
    endtask

    task automatic over_then_reset();
        @(negedge CLK);
        card_a = 4'd9; card_b = 4'd2; bet_a = 8'd3; bet_b = 8'd3;
        fold_a = 1'b0; fold_b = 1'b0; settle = 1'b1;
        @(negedge CLK);
        settle = 1'b0;
        repeat (3) @(negedge CLK);
        check("over_busy", busy, 0);
        check("over_held", game_over, 1);
        check("over_chips_a", chips_a, bal_a);
        check("over_chips_b", chips_b, bal_b);
        reset_dut();
        check_idle_state("reset_after_over");
    endtask

    initial begin
        reset_dut();
        check_idle_state("reset");
        check("reset_err", err, 0);

        run_round(7, 3, 5, 4, 0, 0, 0);
        run_round(10, 4, 2, 6, 1, 0, 0);
        run_round(5, 5, 9, 9, 0, 0, 0);
        run_round(5, 0, 3, 3, 0, 0, 0);
        run_round(3, 8, 4, 7, 1, 1, 1);

        // Reset during a 6-chip transfer after two chips have moved.
        reset_dut();
        @(negedge CLK);
        card_a = 4'd9; card_b = 4'd2; bet_a = 8'd1; bet_b = 8'd6;
        fold_a = 1'b0; fold_b = 1'b0; settle = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        settle = 1'b0;
        repeat (3) @(negedge CLK);
        check("midpay_chips_a", chips_a, INIT + 2);
        check("midpay_chips_b", chips_b, INIT - 2);
        CLR = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        check_idle_state("midpay_reset");
        check("midpay_state_idle", dbg_state, 0);

        // Drive a game to zero with a clamped transfer.
        run_round(9, 2, 1, 30, 0, 0, 0);
        if (game_over) over_then_reset();
        else check("clamp_game_over", game_over, 1);

        for (int r = 0; r < 150; r++) begin
            run_round(rand_card(), rand_card(), $urandom_range(0, 15), $urandom_range(0, 15),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 1);
            if ((bal_a == 0) || (bal_b == 0)) over_then_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
